// File: rtl/stream_cipher_core_pkg.sv
// Shared types and the symbol transform for the stream cipher engine.
package stream_cipher_pkg;

  // Widest symbol the shared transform supports; callers truncate to their own width.
  localparam int unsigned MaxSymW = 32;

  typedef enum logic {
    CIPH_ENC = 1'b0,
    CIPH_DEC = 1'b1
  } cipher_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fsm_state_e;

  // Modular add/subtract; truncating the result to N bits gives arithmetic mod 2^N.
  function automatic logic [MaxSymW-1:0] sym_xform(input logic [MaxSymW-1:0] data,
                                                   input logic [MaxSymW-1:0] key,
                                                   input cipher_mode_e       mode);
    return (mode == CIPH_DEC) ? (data - key) : (data + key);
  endfunction

endpackage

// File: rtl/stream_cipher_core_if.sv
// Valid/ready symbol stream with end-of-message marker.
interface stream_cipher_core_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/stream_cipher_core_keyfile.sv
// Key register file: synchronous write, combinational read at the current key index.
module stream_cipher_keyfile #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] key_q [KEY_LEN];

  // Key storage; writes beyond the populated entries are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_LEN; i++) begin
        key_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < KEY_LEN)) begin
      key_q[waddr_i] <= wdata_i;
    end
  end

  // Read port; out-of-range indices read as zero.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < KEY_LEN) begin
      rdata_o = key_q[raddr_i];
    end
  end

endmodule

// File: rtl/stream_cipher_core.sv
// Byte-serial repeating-key add/subtract cipher with a single-register output stage.
module stream_cipher_core
  import stream_cipher_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned IdxW   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1,
  localparam int unsigned LenW   = $clog2(KEY_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_i,
  input  logic [LenW-1:0]       key_len_i,
  input  logic                  key_we,
  input  logic [IdxW-1:0]       key_addr,
  input  logic [DATA_W-1:0]     key_wdata,
  stream_cipher_core_if.slave   s_if,
  stream_cipher_core_if.master  m_if,
  output logic                  busy,
  output logic                  msg_done,
  output logic                  err,
  output logic [CNT_W-1:0]      byte_cnt
);

  fsm_state_e        state_q, state_d;
  cipher_mode_e      mode_q, mode_d, mode_eff;
  logic [LenW-1:0]   klen_q, klen_d, klen_eff, klen_in;
  logic [IdxW-1:0]   kidx_q, kidx_d, kidx_eff;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;

  logic              accept;
  logic              first_beat;
  logic              last_idx;
  logic              key_wr_ok;
  logic [DATA_W-1:0] key_sym;
  logic [DATA_W-1:0] xform_sym;

  assign s_if.ready = !m_valid_q || m_if.ready;
  assign accept     = s_if.valid && s_if.ready;
  assign first_beat = accept && (state_q == ST_IDLE);

  // Key writes only land while no message is in flight and no beat is being consumed.
  assign key_wr_ok  = key_we && (state_q == ST_IDLE) && !accept;

  // Clamp the requested key length into 1..KEY_LEN.
  always_comb begin
    klen_in = key_len_i;
    if (key_len_i == '0) begin
      klen_in = LenW'(1);
    end else if (32'(key_len_i) > KEY_LEN) begin
      klen_in = LenW'(KEY_LEN);
    end
  end

  // The first beat runs on live controls; later beats use what was latched.
  assign mode_eff = first_beat ? cipher_mode_e'(mode_i) : mode_q;
  assign klen_eff = first_beat ? klen_in : klen_q;
  assign kidx_eff = first_beat ? '0 : kidx_q;
  assign last_idx = (LenW'(kidx_eff) == (klen_eff - LenW'(1)));

  stream_cipher_keyfile #(
    .DATA_W  (DATA_W),
    .KEY_LEN (KEY_LEN),
    .IDX_W   (IdxW)
  ) u_keyfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (key_wr_ok),
    .waddr_i (key_addr),
    .wdata_i (key_wdata),
    .raddr_i (kidx_eff),
    .rdata_o (key_sym)
  );

  assign xform_sym = DATA_W'(sym_xform(MaxSymW'(s_if.data), MaxSymW'(key_sym), mode_eff));

  // Next-state for message control, key index, counter and error flag.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    klen_d  = klen_q;
    kidx_d  = kidx_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (key_we & ((state_q == ST_ACTIVE) | accept));
    if (accept) begin
      state_d = s_if.last ? ST_IDLE : ST_ACTIVE;
      kidx_d  = last_idx ? '0 : (kidx_eff + IdxW'(1));
    end
    if (first_beat) begin
      mode_d = mode_eff;
      klen_d = klen_eff;
      cnt_d  = CNT_W'(1);
    end else if (accept && (cnt_q != '1)) begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Message-control FSM and its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= CIPH_ENC;
      klen_q  <= LenW'(1);
      kidx_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      klen_q  <= klen_d;
      kidx_q  <= kidx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Output register next-state: load on accept, drain on downstream ready, else hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = xform_sym;
      m_last_d  = s_if.last;
    end else if (m_if.ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Output stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;

  assign busy     = (state_q == ST_ACTIVE);
  assign msg_done = m_valid_q && m_last_q && m_if.ready;
  assign err      = err_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_stream_cipher_core.sv
// Directed bench for stream_cipher_core with hand-computed vectors.
module tb_stream_cipher_core;

  typedef logic [7:0] sym_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_i = 1'b0;
  logic [2:0]  key_len_i = 3'd3;
  logic        key_we = 1'b0;
  logic [1:0]  key_addr = 2'd0;
  logic [7:0]  key_wdata = 8'd0;
  logic        busy;
  logic        msg_done;
  logic        err;
  logic [15:0] byte_cnt;

  stream_cipher_core_if #(.DATA_W(8)) s_if ();
  stream_cipher_core_if #(.DATA_W(8)) m_if ();

  stream_cipher_core #(
    .DATA_W  (8),
    .KEY_LEN (4),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .key_len_i (key_len_i),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .s_if      (s_if),
    .m_if      (m_if),
    .busy      (busy),
    .msg_done  (msg_done),
    .err       (err),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  // "PARASCHIV" and its encryption under key 4B 45 59 (key_len 3).
  sym_q_t plain  = '{8'h50, 8'h41, 8'h52, 8'h41, 8'h53, 8'h43, 8'h48, 8'h49, 8'h56};
  sym_q_t cipher = '{8'h9B, 8'h86, 8'hAB, 8'h8C, 8'h98, 8'h9C, 8'h93, 8'h8E, 8'hAF};

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  rx_data[$];
  logic        rx_last[$];
  int unsigned done_cnt = 0;
  int unsigned busy_cnt = 0;

  // Monitor: inputs change just after posedge, so negedge sees settled handshakes.
  always @(negedge clk) begin
    if (m_if.valid && m_if.ready) begin
      rx_data.push_back(m_if.data);
      rx_last.push_back(m_if.last);
    end
    if (msg_done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = last;
    @(negedge clk);
    while (!s_if.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_if.ready) check("s_accept_timeout", 32'(s_if.ready), 32'd1);
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic send_msg(input sym_q_t msg);
    for (int i = 0; i < msg.size(); i++) begin
      send_beat(msg[i], i == msg.size() - 1);
    end
  endtask

  task automatic write_key(input logic [1:0] a, input logic [7:0] d);
    key_we    = 1'b1;
    key_addr  = a;
    key_wdata = d;
    @(posedge clk);
    #1;
    key_we    = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_msg(input string tag, input int base, input int dbase, input sym_q_t exp);
    check({tag, "_len"}, 32'(rx_data.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < rx_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 32'(rx_data[base + i]), 32'(exp[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(rx_last[base + i]),
              32'(i == exp.size() - 1));
      end
    end
    check({tag, "_done"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    int dbase;
    int bbase;
    int idx;

    s_if.valid  = 1'b0;
    s_if.data   = 8'd0;
    s_if.last   = 1'b0;
    m_if.ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_if.valid), 32'd0);
    check("rst_m_data", 32'(m_if.data), 32'd0);
    check("rst_m_last", 32'(m_if.last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_done", 32'(msg_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    write_key(2'd0, 8'h4B);
    write_key(2'd1, 8'h45);
    write_key(2'd2, 8'h59);
    write_key(2'd3, 8'hEE);

    // 1: encrypt
    base = rx_data.size(); dbase = done_cnt;
    mode_i = 1'b0; key_len_i = 3'd3;
    send_msg(plain);
    drain();
    check_msg("t1", base, dbase, cipher);
    check("t1_byte_cnt", 32'(byte_cnt), 32'd9);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // 2: decrypt round trip
    base = rx_data.size(); dbase = done_cnt;
    mode_i = 1'b1;
    send_msg(cipher);
    drain();
    check_msg("t2", base, dbase, plain);
    check("t2_byte_cnt", 32'(byte_cnt), 32'd9);

    // 3: wrap-around on single-beat messages
    write_key(2'd0, 8'h20);
    key_len_i = 3'd1; mode_i = 1'b0;
    base = rx_data.size(); dbase = done_cnt; bbase = busy_cnt;
    send_msg('{8'hF0});
    drain();
    check_msg("t3enc", base, dbase, '{8'h10});
    check("t3enc_busy", 32'(busy_cnt - bbase), 32'd0);
    check("t3enc_byte_cnt", 32'(byte_cnt), 32'd1);
    key_len_i = 3'd0; mode_i = 1'b1;
    base = rx_data.size(); dbase = done_cnt; bbase = busy_cnt;
    send_msg('{8'h10});
    drain();
    check_msg("t3dec", base, dbase, '{8'hF0});
    check("t3dec_busy", 32'(busy_cnt - bbase), 32'd0);
    write_key(2'd0, 8'h4B);

    // 4: backpressure mid-message
    key_len_i = 3'd3; mode_i = 1'b0;
    base = rx_data.size(); dbase = done_cnt;
    fork
      send_msg(plain);
      begin
        repeat (4) @(posedge clk);
        #1;
        m_if.ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("t4_s_ready", 32'(s_if.ready), 32'd0);
          check("t4_m_valid", 32'(m_if.valid), 32'd1);
          idx = rx_data.size() - base;
          if (idx < 9) check("t4_stall_data", 32'(m_if.data), 32'(cipher[idx]));
        end
        @(posedge clk);
        #1;
        m_if.ready = 1'b1;
      end
    join
    drain();
    check_msg("t4", base, dbase, cipher);

    // 5: illegal key write and mode toggle while busy
    base = rx_data.size(); dbase = done_cnt;
    fork
      send_msg(plain);
      begin
        repeat (3) @(posedge clk);
        #1;
        key_we = 1'b1; key_addr = 2'd0; key_wdata = 8'h00;
        mode_i = 1'b1; key_len_i = 3'd1;
        @(posedge clk);
        #1;
        key_we = 1'b0;
      end
    join
    drain();
    check_msg("t5", base, dbase, cipher);
    check("t5_err", 32'(err), 32'd1);
    mode_i = 1'b0; key_len_i = 3'd3;
    base = rx_data.size(); dbase = done_cnt;
    send_msg('{8'h50});
    drain();
    check_msg("t5_key0", base, dbase, '{8'h9B});

    // 6: reset mid-message
    for (int i = 0; i < 4; i++) send_beat(plain[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_m_valid", 32'(m_if.valid), 32'd0);
    check("t6_byte_cnt", 32'(byte_cnt), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = rx_data.size(); dbase = done_cnt;
    write_key(2'd0, 8'h4B);
    write_key(2'd1, 8'h45);
    write_key(2'd2, 8'h59);
    check("t6_no_output", 32'(rx_data.size() - base), 32'd0);
    send_msg('{8'h50, 8'h41, 8'h52});
    drain();
    check_msg("t6", base, dbase, '{8'h9B, 8'h86, 8'hAB});
    check("t6_byte_cnt_new", 32'(byte_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_cipher_core.md
Name: stream_cipher_core

Overview:
Byte-serial, clocked successor to the combinational encrypt/decrypt pair.
- Processes messages of any length on a valid/ready stream instead of a fixed MSG_LEN array.
- Supports runtime encrypt/decrypt mode and a loadable repeating key of programmable length.
- Sits between a message source (UART/test FIFO) and a sink. One engine serves both directions.

Parameters:
- DATA_W, 8, symbol width in bits; arithmetic is mod 2^DATA_W.
- KEY_LEN, 4, maximum key symbols held in the key register file.
- CNT_W, 16, width of the per-message symbol counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  1  0=encrypt, 1=decrypt; sampled at the first beat of a message.
- key_len_i  in  $clog2(KEY_LEN+1)  active key length, 1..KEY_LEN; sampled at the first beat. A value of 0 is treated as 1.
- key_we  in  1  key register write strobe.
- key_addr  in  $clog2(KEY_LEN)  key register index.
- key_wdata  in  DATA_W  key symbol.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  input symbol accepted when s_valid && s_ready.
- s_data  in  DATA_W  input symbol.
- s_last  in  1  final symbol of the message.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  DATA_W  transformed symbol.
- m_last  out  1  final output symbol of the message.
- busy  out  1  high while a message is in progress (state ACTIVE).
- msg_done  out  1  one-cycle pulse when the m_last beat is accepted downstream.
- err  out  1  sticky flag: key write attempted while busy.
- byte_cnt  out  CNT_W  symbols accepted in the current/last message.

Behaviour:
- Reset (async assert, synchronous deassert by the integrator):
  - Outputs: m_valid=0, m_data=0, m_last=0, busy=0, msg_done=0, err=0, byte_cnt=0.
  - Internal: key registers=0, key index=0, FSM=IDLE.
  - Reset mid-message discards all in-flight data; no m_last is emitted.
- FSM states: IDLE, ACTIVE.
  - IDLE->ACTIVE on an accepted beat with s_last=0.
  - On an accepted beat with s_last=1 the FSM stays in/returns to IDLE; a single-symbol message never enters ACTIVE.
  - ACTIVE->IDLE on an accepted beat with s_last=1.
- Latching: mode and key_len are latched on the first accepted beat in IDLE. Changes while ACTIVE have no effect until the next message.
- Transform, with k = key index:
  - Encrypt: m_data = s_data + key[k] mod 2^DATA_W.
  - Decrypt: m_data = s_data - key[k] mod 2^DATA_W.
  - The first beat uses the live mode_i/key_len_i, k=0.
- Key index:
  - Increments per accepted beat and wraps to 0 after latched key_len-1.
  - Resets to 0 at each message start.
- Output stage: single register.
  - Latency: 1 cycle from input acceptance to m_valid.
  - s_ready = !m_valid || m_ready, so full throughput with no bubbles.
  - m_data/m_last hold stable while m_valid && !m_ready.
- byte_cnt:
  - Loads 1 on the first beat, then increments per accepted beat.
  - Saturates at 2^CNT_W-1.
  - Holds its value after the message ends until the next message starts.
- Key writes:
  - Accepted only when busy=0 and the accept condition is absent that cycle.
  - A key_we while busy is ignored and sets err.
  - Simultaneous key_we and first-beat acceptance: the beat uses the old key, the write is ignored, and err is set.
  - err clears only on reset.
- msg_done: one pulse per message, in the cycle the m_last beat handshakes downstream.

Decomposition:
- Package stream_cipher_pkg holds:
  - typedef cipher_mode_e {CIPH_ENC=1'b0, CIPH_DEC=1'b1};
  - typedef fsm_state_e {ST_IDLE, ST_ACTIVE};
  - function sym_xform(data, key, mode), shared with the bench reference model.
- Sub-module stream_cipher_keyfile: KEY_LEN x DATA_W register file with write port and combinational read at the key index.

Test Plan:
1. Encrypt a message, setup KEY_LEN=4, key={0x4B,0x45,0x59,x}, key_len_i=3, mode=0, m_ready=1.
   Input "PARASCHIV" -> m_data 9B 86 AB 8C 98 9C 93 8E AF, m_last on the 9th beat, byte_cnt=9, one msg_done.
2. Round trip: feed the output of scenario 1 back with mode=1 -> "PARASCHIV" recovered exactly.
3. Wrap-around: key[0]=0x20, encrypt 0xF0 -> 0x10; decrypt 0x10 -> 0xF0. Single-beat message with s_last=1 -> busy never asserts, msg_done pulses once.
4. Backpressure: hold m_ready=0 for 5 cycles mid-message -> s_ready=0 after one buffered beat, m_data stable, no symbol lost or duplicated once released.
5. Illegal key write: key_we while busy -> err=1, the key is unchanged and the current message output matches scenario 1. A mode_i toggle mid-message has no effect.
6. Reset mid-message: rst_n low after 4 beats -> m_valid=0, byte_cnt=0, err=0 immediately. The next message restarts at key index 0.
